// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port-0 arbiter
package sram_arb_pkg;

    typedef enum logic {REQ_IF, REQ_LS} req_id_t;

    localparam int RSP_LATENCY   = 2;
    localparam int SRAM_WORD_LSB = 2;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    is_read;
    } stage_t;

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: picks IF or LS as the owner of SRAM port 0 each cycle
// Build option SRAM_ARB_RR_EN: round-robin tie breaking replaces fixed LS priority
// and its IF starvation escape.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_if_valid,
    input  logic    i_ls_valid,
    output logic    o_grant,
    output req_id_t o_winner
);

    assign o_grant = !reset && (i_if_valid || i_ls_valid);

`ifdef SRAM_ARB_RR_EN
    req_id_t r_ptr;

    // IF wins when alone, or on a tie when the pointer favours it
    always_comb o_winner = (i_if_valid && (!i_ls_valid || r_ptr == REQ_IF)) ? REQ_IF : REQ_LS;

    // after every tie the pointer moves to the requester that lost it
    always_ff @(posedge clk or posedge reset)
        if (reset) r_ptr <= REQ_IF;
        else if (i_if_valid && i_ls_valid) r_ptr <= (o_winner == REQ_IF) ? REQ_LS : REQ_IF;
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          w_if_pri;

    assign w_if_pri = (r_starve_cnt == CW'(STARVE_LIMIT));

    // LS wins ties unless IF has lost STARVE_LIMIT cycles in a row
    always_comb o_winner = (i_if_valid && (!i_ls_valid || w_if_pri)) ? REQ_IF : REQ_LS;

    // count IF losses, saturating; any IF grant clears the count
    always_ff @(posedge clk or posedge reset)
        if (reset) r_starve_cnt <= '0;
        else if (o_grant && o_winner == REQ_IF) r_starve_cnt <= '0;
        else if (i_if_valid && !w_if_pri) r_starve_cnt <= r_starve_cnt + CW'(1);
`endif

endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares RW port 0 of the SRAM macro between instruction fetch and load/store
// Macro inputs are driven combinationally in the grant cycle; read data comes back two
// cycles later, tagged to the requester. Build option SRAM_ARB_RR_EN selects round-robin
// arbitration instead of fixed LS priority with IF starvation escape.
module sram_port0_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WMASKS   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    input  logic [31:0]           if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  ls_req_valid,
    input  logic                  ls_req_we,
    input  logic [31:0]           ls_req_addr,
    input  logic [NUM_WMASKS-1:0] ls_req_wmask,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    output logic                  ls_req_ready,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    logic                     w_grant;
    req_id_t                  w_winner;
    logic                     w_store;
    logic [ADDR_WIDTH-1:0]    w_addr;
    stage_t                   w_stage;
    stage_t                   w_rsp;
    logic                     w_unused;
    stage_t [RSP_LATENCY-1:0] r_pipe;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_din;
    logic [NUM_WMASKS-1:0]    r_wmask;
    logic [DATA_WIDTH-1:0]    r_rsp_data;

    assign w_unused = &{1'b0, if_req_addr[31:ADDR_WIDTH+2], if_req_addr[SRAM_WORD_LSB-1:0],
                        ls_req_addr[31:ADDR_WIDTH+2], ls_req_addr[SRAM_WORD_LSB-1:0]};

    sram_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk        (clk),
        .reset      (reset),
        .i_if_valid (if_req_valid),
        .i_ls_valid (ls_req_valid),
        .o_grant    (w_grant),
        .o_winner   (w_winner)
    );

    // handshake, macro drive (idle cycles hold addr/din/wmask) and pipeline entry
    always_comb begin
        if_req_ready = w_grant && w_winner == REQ_IF;
        ls_req_ready = w_grant && w_winner == REQ_LS;
        w_store      = ls_req_ready && ls_req_we;
        w_addr       = (w_winner == REQ_LS) ? ls_req_addr[ADDR_WIDTH+1:SRAM_WORD_LSB]
                                            : if_req_addr[ADDR_WIDTH+1:SRAM_WORD_LSB];
        csb0         = !w_grant;
        web0         = !w_store;
        addr0        = w_grant ? w_addr : r_addr;
        wmask0       = w_grant ? (w_store ? ls_req_wmask : '0) : r_wmask;
        din0         = w_store ? ls_req_wdata : r_din;
        w_stage      = '{valid: w_grant, id: w_winner, is_read: !w_store};
        w_rsp        = r_pipe[RSP_LATENCY-1];
        if_rsp_valid = w_rsp.valid && w_rsp.is_read && w_rsp.id == REQ_IF;
        ls_rsp_valid = w_rsp.valid && w_rsp.is_read && w_rsp.id == REQ_LS;
        if_rsp_data  = r_rsp_data;
        ls_rsp_data  = r_rsp_data;
    end

    // remember last macro drive, shift the response pipe, capture read data a cycle after grant
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_addr     <= '0;
            r_din      <= '0;
            r_wmask    <= '0;
            r_pipe     <= '0;
            r_rsp_data <= '0;
        end else begin
            r_addr  <= addr0;
            r_din   <= din0;
            r_wmask <= wmask0;
            r_pipe  <= {r_pipe[RSP_LATENCY-2:0], w_stage};
            if (r_pipe[0].valid && r_pipe[0].is_read) r_rsp_data <= dout0;
        end

endmodule
